code39_char_decoder: RTL and testbench
======================================

// Module: code39_char_decoder
// PURPOSE
//  Consumes the bar/space width samples produced by the 8254-style width timer (one sample per
//  GATE0 toggle, strobed like DREQ). Classifies each element narrow/wide, frames 9-element
//  Code 39 symbols between '*' start/stop guards, and emits decoded ASCII through a valid/ready
//  output register. Sits between the width timer and the character buffer / display logic.
// PARAMETERS
//  W_BITS   4   width of width_in sample
//  THRESH   6   width_in >= THRESH is wide (1); 1..THRESH-1 is narrow (0)
//  ELEMS    9   elements per symbol (5 bars + 4 spaces, separator gap excluded upstream)
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-low
//  cs           in   1       block enable; low = ignore width_valid, hold all state and outputs
//  width_in     in   W_BITS  element width in clk counts
//  width_valid  in   1       one-cycle strobe, width_in valid
//  char_out     out  8       decoded ASCII character
//  char_valid   out  1       char_out holds an unconsumed character
//  char_ready   in   1       consumer accepts char_out when char_valid & char_ready
//  frame_active out  1       high between accepted start '*' and stop '*'
//  frame_done   out  1       one-cycle pulse on stop '*'
//  err          out  1       one-cycle error pulse
//  err_code     out  2       01 bad pattern, 10 output overflow, 11 zero width; valid with err
// BEHAVIOUR
//  Reset: char_out=0, char_valid=0, frame_active=0, frame_done=0, err=0, err_code=0,
//   shift reg=0, elem_cnt=0, state=HUNT. Reset mid-frame drops the frame and any pending char.
//  Element capture (cs & width_valid): wide = (width_in >= THRESH); shifted into 9-bit
//   pattern reg LSB-in, so first element of a symbol ends in bit 8.
//  width_in==0: element ignored (no shift, no count), err=1, err_code=11, state unchanged.
//  FSM states:
//   HUNT: sliding window; after each element, if pattern == STAR (9'b010010100) -> DATA,
//         elem_cnt=0, frame_active=1. No chars emitted, no bad-pattern errors in HUNT.
//   DATA: elem_cnt counts 0..8; on 9th element (cnt==8) lookup the completed pattern, cnt->0:
//         - STAR: frame_done=1 next cycle, frame_active=0, -> HUNT (STAR never emitted).
//         - valid non-STAR char: load output register (see below), stay DATA.
//         - no table hit: err=1/01, frame_active=0, -> HUNT (resync).
//  Lookup table: the 43 Code 39 characters 0-9, A-Z, '-', '.', ' ', '$', '/', '+', '%' plus '*';
//   every legal code has exactly 3 wide elements. Examples: '0'=9'b000110100, 'A'=9'b100001001.
//  Output register / handshake:
//   - char_valid set and char_out loaded the cycle after the 9th width_valid (latency 1).
//   - char_valid & char_ready: character consumed, char_valid cleared unless a new char loads
//     in the same cycle (new char replaces, char_valid stays 1, no error).
//   - new char while char_valid & ~char_ready: new char dropped, char_out unchanged,
//     err=1/10, FSM continues in DATA.
//   - char_out stable while char_valid=1 and not consumed.
//  err, frame_done: single-cycle pulses, 0 otherwise. Overlap priority for err_code: 11 > 01 > 10.
//  cs low: width_valid ignored; handshake outputs hold (char_ready ignored too).
//  Upstream guarantees at most one width_valid per 2 clk; block must still accept back-to-back.
// STRUCTURE
//  Package code39_pkg: state typedef {HUNT, DATA}; STAR pattern constant; err_code constants;
//   default THRESH.
//  Sub-module code39_lookup: combinational 9-bit pattern -> {hit, is_star, ascii[7:0]} ROM.
//  Top: classifier, shift reg, elem_cnt, FSM, output register.
// TESTING
//  1 Widths for "*A*" (narrow=4, wide=8) -> char_out=8'h41 char_valid 1 cycle after 18th
//    strobe, frame_done pulse after 27th, frame_active 1 between them.
//  2 Noise elements (5 random) before "*0*" -> no err, single char 8'h30, frame_done once.
//  3 In frame, 9-element pattern with 4 wide -> err=1 err_code=01, frame_active=0, next "*" relocks.
//  4 "*AB*" with char_ready=0 -> 'A' held, 'B' dropped with err_code=10; then ready=1 with
//    a new char the same cycle -> replace, char_valid stays 1, no err.
//  5 width_in=0 strobe mid-symbol -> err_code=11, elem_cnt unchanged, symbol still decodes.
//  6 Assert rst after 5th element of 'A' -> all outputs 0, state HUNT; cs=0 strobes -> no change.

Source files
------------

// File: rtl/code39_pkg.sv
// Shared types and constants for the Code 39 character decoder.
// Patterns are 9 elements, first element in bit 8, 1 = wide.
package code39_pkg;

  localparam int SYM_W      = 9;
  localparam int DEF_THRESH = 6;

  localparam logic [SYM_W-1:0] STAR = 9'b010010100;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_BAD  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_ZERO = 2'b11;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

endpackage

// File: rtl/code39_lookup.sv
// Combinational Code 39 pattern ROM: 9-element narrow/wide pattern to ASCII.
// hit is low for any pattern outside the 44-entry table.
module code39_lookup
  import code39_pkg::*;
(
  input  logic [SYM_W-1:0] pattern,
  output logic             hit,
  output logic             is_star,
  output logic [7:0]       ascii
);

  always_comb begin
    hit     = 1'b1;
    is_star = 1'b0;
    ascii   = 8'h00;
    case (pattern)
      9'b000110100: ascii = "0";
      9'b100100001: ascii = "1";
      9'b001100001: ascii = "2";
      9'b101100000: ascii = "3";
      9'b000110001: ascii = "4";
      9'b100110000: ascii = "5";
      9'b001110000: ascii = "6";
      9'b000100101: ascii = "7";
      9'b100100100: ascii = "8";
      9'b001100100: ascii = "9";
      9'b100001001: ascii = "A";
      9'b001001001: ascii = "B";
      9'b101001000: ascii = "C";
      9'b000011001: ascii = "D";
      9'b100011000: ascii = "E";
      9'b001011000: ascii = "F";
      9'b000001101: ascii = "G";
      9'b100001100: ascii = "H";
      9'b001001100: ascii = "I";
      9'b000011100: ascii = "J";
      9'b100000011: ascii = "K";
      9'b001000011: ascii = "L";
      9'b101000010: ascii = "M";
      9'b000010011: ascii = "N";
      9'b100010010: ascii = "O";
      9'b001010010: ascii = "P";
      9'b000000111: ascii = "Q";
      9'b100000110: ascii = "R";
      9'b001000110: ascii = "S";
      9'b000010110: ascii = "T";
      9'b110000001: ascii = "U";
      9'b011000001: ascii = "V";
      9'b111000000: ascii = "W";
      9'b010010001: ascii = "X";
      9'b110010000: ascii = "Y";
      9'b011010000: ascii = "Z";
      9'b010000101: ascii = "-";
      9'b110000100: ascii = ".";
      9'b011000100: ascii = " ";
      9'b010101000: ascii = "$";
      9'b010100010: ascii = "/";
      9'b010001010: ascii = "+";
      9'b000101010: ascii = "%";
      STAR: begin
        ascii   = "*";
        is_star = 1'b1;
      end
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/code39_char_decoder.sv
// Code 39 decoder: classifies bar/space widths, frames symbols between '*' guards
// and presents decoded ASCII through a single valid/ready output register.
module code39_char_decoder
  import code39_pkg::*;
#(
  parameter int W_BITS = 4,
  parameter int THRESH = DEF_THRESH,
  parameter int ELEMS  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [W_BITS-1:0] width_in,
  input  logic              width_valid,
  output logic [7:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              frame_active,
  output logic              frame_done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int                CW   = $clog2(ELEMS);
  localparam logic [W_BITS-1:0] THR  = W_BITS'(THRESH);
  localparam logic [CW-1:0]     LAST = CW'(ELEMS - 1);

  state_t           state_reg, state_next;
  logic [SYM_W-1:0] pat_reg, pat_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [7:0]       char_out_reg, char_out_next;
  logic             char_valid_reg, char_valid_next;
  logic             frame_done_reg, frame_done_next;
  logic             err_reg, err_next;
  logic [1:0]       err_code_reg, err_code_next;

  logic [SYM_W-1:0] shifted;
  logic             lut_hit, lut_star;
  logic [7:0]       lut_ascii;

  // Lookup runs on the pattern including the element arriving this cycle.
  assign shifted = {pat_reg[SYM_W-2:0], (width_in >= THR)};

  code39_lookup u_lookup (
    .pattern (shifted),
    .hit     (lut_hit),
    .is_star (lut_star),
    .ascii   (lut_ascii)
  );

  always_comb begin
    state_next      = state_reg;
    pat_next        = pat_reg;
    cnt_next        = cnt_reg;
    char_out_next   = char_out_reg;
    char_valid_next = char_valid_reg;
    frame_done_next = 1'b0;
    err_next        = 1'b0;
    err_code_next   = ERR_NONE;
    if (cs) begin
      if (char_valid_reg && char_ready) char_valid_next = 1'b0;
      if (width_valid) begin
        if (width_in == '0) begin
          err_next      = 1'b1;
          err_code_next = ERR_ZERO;
        end else begin
          pat_next = shifted;
          case (state_reg)
            HUNT: begin
              if (shifted == STAR) begin
                state_next = DATA;
                cnt_next   = '0;
              end
            end
            DATA: begin
              if (cnt_reg == LAST) begin
                cnt_next = '0;
                if (!lut_hit) begin
                  err_next      = 1'b1;
                  err_code_next = ERR_BAD;
                  state_next    = HUNT;
                end else if (lut_star) begin
                  frame_done_next = 1'b1;
                  state_next      = HUNT;
                end else if (!char_valid_reg || char_ready) begin
                  // A char consumed this cycle frees the register for the new one.
                  char_out_next   = lut_ascii;
                  char_valid_next = 1'b1;
                end else begin
                  err_next      = 1'b1;
                  err_code_next = ERR_OVF;
                end
              end else begin
                cnt_next = cnt_reg + 1'b1;
              end
            end
            default: state_next = HUNT;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= HUNT;
      pat_reg        <= '0;
      cnt_reg        <= '0;
      char_out_reg   <= '0;
      char_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
    end else begin
      state_reg      <= state_next;
      pat_reg        <= pat_next;
      cnt_reg        <= cnt_next;
      char_out_reg   <= char_out_next;
      char_valid_reg <= char_valid_next;
      frame_done_reg <= frame_done_next;
      err_reg        <= err_next;
      err_code_reg   <= err_code_next;
    end
  end

  assign char_out     = char_out_reg;
  assign char_valid   = char_valid_reg;
  assign frame_active = (state_reg == DATA);
  assign frame_done   = frame_done_reg;
  assign err          = err_reg;
  assign err_code     = err_code_reg;

endmodule

// File: tb/tb_code39_char_decoder.sv
// Directed bench for code39_char_decoder: hand-computed Code 39 symbols,
// checked with immediate assertions after each step.
module tb_code39_char_decoder;

  localparam logic [8:0] P_STAR = 9'b010010100;
  localparam logic [8:0] P_A    = 9'b100001001;
  localparam logic [8:0] P_B    = 9'b001001001;
  localparam logic [8:0] P_0    = 9'b000110100;
  localparam logic [8:0] P_BAD  = 9'b111100000;
  localparam logic [3:0] NARROW = 4'd4;
  localparam logic [3:0] WIDE   = 4'd8;

  logic       clk;
  logic       rst;
  logic       cs;
  logic [3:0] width_in;
  logic       width_valid;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       frame_active;
  logic       frame_done;
  logic       err;
  logic [1:0] err_code;

  int passed = 0;
  int total  = 0;

  code39_char_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .cs           (cs),
    .width_in     (width_in),
    .width_valid  (width_valid),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .err          (err),
    .err_code     (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Sends pattern bits hi..lo; one idle cycle between strobes unless b2b.
  // rdy_last raises char_ready in the same cycle as the final strobe.
  task automatic send_elems(input logic [8:0] p, input int hi, input int lo,
                            input bit rdy_last, input bit b2b);
    for (int i = hi; i >= lo; i--) begin
      @(negedge clk);
      width_in    = p[i] ? WIDE : NARROW;
      width_valid = 1'b1;
      if (i == lo && rdy_last) char_ready = 1'b1;
      if (!b2b) begin
        @(negedge clk);
        width_valid = 1'b0;
      end
    end
    if (b2b) begin
      @(negedge clk);
      width_valid = 1'b0;
    end
  endtask

  task automatic strobe(input logic [3:0] w);
    @(negedge clk);
    width_in    = w;
    width_valid = 1'b1;
    @(negedge clk);
    width_valid = 1'b0;
  endtask

  task automatic consume();
    char_ready = 1'b1;
    @(negedge clk);
    char_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] noise [5];
    noise = '{4'd8, 4'd13, 4'd6, 4'd15, 4'd10};
    rst = 1'b0; cs = 1'b1; width_in = '0; width_valid = 1'b0; char_ready = 1'b0;
    #12;
    chk("rst_char_out", char_out, 8'h00);
    chk("rst_char_valid", char_valid, 1'b0);
    chk("rst_frame_active", frame_active, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_err", {err, err_code}, 3'b000);
    @(negedge clk);
    rst = 1'b1;

    // 1: "*A*"
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    chk("t1_lock", frame_active, 1'b1);
    chk("t1_no_char", char_valid, 1'b0);
    send_elems(P_A, 8, 0, 1'b0, 1'b0);
    chk("t1_char", char_out, 8'h41);
    chk("t1_valid", char_valid, 1'b1);
    chk("t1_active", frame_active, 1'b1);
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    chk("t1_done", frame_done, 1'b1);
    chk("t1_inactive", frame_active, 1'b0);
    chk("t1_held", {char_valid, char_out}, {1'b1, 8'h41});
    @(negedge clk);
    chk("t1_done_pulse", frame_done, 1'b0);
    consume();
    chk("t1_consumed", char_valid, 1'b0);

    // 2: noise then "*0*", back-to-back strobes
    for (int i = 0; i < 5; i++) strobe(noise[i]);
    chk("t2_noise_err", err, 1'b0);
    chk("t2_noise_hunt", frame_active, 1'b0);
    send_elems(P_STAR, 8, 0, 1'b0, 1'b1);
    chk("t2_lock", frame_active, 1'b1);
    send_elems(P_0, 8, 0, 1'b0, 1'b1);
    chk("t2_char", {char_valid, char_out}, {1'b1, 8'h30});
    chk("t2_no_err", err, 1'b0);
    send_elems(P_STAR, 8, 0, 1'b0, 1'b1);
    chk("t2_done", frame_done, 1'b1);
    @(negedge clk);
    chk("t2_done_once", frame_done, 1'b0);
    consume();

    // 3: four-wide pattern in frame, then relock
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    chk("t3_lock", frame_active, 1'b1);
    send_elems(P_BAD, 8, 0, 1'b0, 1'b0);
    chk("t3_err", {err, err_code}, 3'b101);
    chk("t3_drop", frame_active, 1'b0);
    chk("t3_no_char", char_valid, 1'b0);
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    chk("t3_relock", frame_active, 1'b1);
    chk("t3_err_clear", err, 1'b0);
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    chk("t3_done", frame_done, 1'b1);

    // 4: "*AB*" with consumer stalled, then replace on accept
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    send_elems(P_A, 8, 0, 1'b0, 1'b0);
    chk("t4_a", {char_valid, char_out}, {1'b1, 8'h41});
    send_elems(P_B, 8, 0, 1'b0, 1'b0);
    chk("t4_ovf", {err, err_code}, 3'b110);
    chk("t4_a_kept", {char_valid, char_out}, {1'b1, 8'h41});
    chk("t4_still_data", frame_active, 1'b1);
    send_elems(P_0, 8, 0, 1'b1, 1'b0);
    char_ready = 1'b0;
    chk("t4_replace", {char_valid, char_out}, {1'b1, 8'h30});
    chk("t4_replace_no_err", err, 1'b0);
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    chk("t4_done", frame_done, 1'b1);
    consume();
    chk("t4_consumed", char_valid, 1'b0);

    // 5: zero-width strobe inside a symbol
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    send_elems(P_A, 8, 5, 1'b0, 1'b0);
    strobe(4'd0);
    chk("t5_zero_err", {err, err_code}, 3'b111);
    chk("t5_active", frame_active, 1'b1);
    send_elems(P_A, 4, 0, 1'b0, 1'b0);
    chk("t5_char", {char_valid, char_out}, {1'b1, 8'h41});
    chk("t5_err_clear", err, 1'b0);
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    chk("t5_done", frame_done, 1'b1);
    consume();

    // 6: async reset mid-symbol with a char pending, then cs gating
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    send_elems(P_A, 8, 0, 1'b0, 1'b0);
    send_elems(P_A, 8, 4, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_char", {char_valid, char_out}, 9'h000);
    chk("t6_rst_frame", {frame_active, frame_done, err, err_code}, 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    cs = 1'b0;
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    chk("t6_cs_ignored", frame_active, 1'b0);
    cs = 1'b1;
    send_elems(P_STAR, 8, 0, 1'b0, 1'b0);
    chk("t6_lock", frame_active, 1'b1);
    send_elems(P_A, 8, 0, 1'b0, 1'b0);
    chk("t6_char", {char_valid, char_out}, {1'b1, 8'h41});
    cs = 1'b0;
    char_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_cs_hold", {char_valid, char_out}, {1'b1, 8'h41});
    cs = 1'b1;
    @(negedge clk);
    char_ready = 1'b0;
    chk("t6_cs_consume", char_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
